// File: rtl/pwm_gen.sv
// PWM generator: period counter advanced by synchronized clk_div rising edges,
// double-buffered duty with a ready/valid load port, and IDLE/RUN/DRAIN control.
module pwm_gen #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PERIOD = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_end,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             sync1, sync2, sync3, armed, tick;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] active_duty, active_nxt;
    logic [CNT_W-1:0] pending, pending_nxt;
    logic             pend_full, pend_full_nxt;
    logic             wrap, promote;

    // Synchronizer and edge detect; armed blocks a tick until clk_div has been seen low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            armed <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= clk_div;
            sync2 <= sync1;
            sync3 <= sync2;
            armed <= armed | ~sync2;
            tick  <= armed & sync2 & ~sync3;
        end
    end

    assign wrap    = tick && (cnt == LAST) && (state != IDLE);
    assign promote = wrap || ((state == IDLE) && enable);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = wrap ? IDLE : DRAIN;
            DRAIN: begin
                if (enable)    state_nxt = RUN;
                else if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter and duty buffering; a load never collides with a promote since it needs pend_full low
    always_comb begin
        cnt_nxt       = cnt;
        active_nxt    = active_duty;
        pending_nxt   = pending;
        pend_full_nxt = pend_full;
        if (state == IDLE) begin
            cnt_nxt = '0;
        end else if (tick) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
        if (promote && pend_full) begin
            active_nxt    = pending;
            pend_full_nxt = 1'b0;
        end
        if (duty_valid && !pend_full) begin
            pending_nxt   = duty_in;
            pend_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            active_duty <= '0;
            pending     <= '0;
            pend_full   <= 1'b0;
            duty_ready  <= 1'b1;
            pwm_out     <= 1'b0;
            period_end  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            active_duty <= active_nxt;
            pending     <= pending_nxt;
            pend_full   <= pend_full_nxt;
            duty_ready  <= !pend_full_nxt;
            pwm_out     <= (state != IDLE) && (cnt < active_duty);
            period_end  <= wrap;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: per-period high-time and length compared with a duty model
// that tracks which requested value owns each period.
module tb_pwm_gen;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERIOD = 10;
    localparam int TICK_CLKS = 4;
    localparam int WIN = PERIOD * TICK_CLKS;

    logic             clk, rst, clk_div, enable, duty_valid;
    logic [CNT_W-1:0] duty_in;
    logic             duty_ready, pwm_out, period_end, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_duty = 0;
    bit div_run  = 1'b1;
    bit div_hold = 1'b0;

    pwm_gen #(.CNT_W(CNT_W), .PERIOD(PERIOD)) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .enable(enable),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm_out(pwm_out), .period_end(period_end), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clk_div: square wave of TICK_CLKS clocks, or held at div_hold
    initial begin
        int dc;
        dc = 0;
        clk_div = 1'b0;
        forever begin
            @(negedge clk);
            if (!div_run) begin
                clk_div = div_hold;
                dc = 0;
            end else begin
                dc++;
                if (dc == TICK_CLKS / 2) begin
                    clk_div = ~clk_div;
                    dc = 0;
                end
            end
        end
    end

    function automatic int exp_hi(input int d);
        return ((d > int'(PERIOD)) ? int'(PERIOD) : d) * TICK_CLKS;
    endfunction

    task automatic wait_pe();
        int k;
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (period_end) break;
            k++;
        end
        n_checks++;
        if (period_end !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_period_end: period_end=%0b after %0d cycles, required 1", period_end, k);
        end
    endtask

    // Runs from one period_end cycle to the next, counting pwm high cycles and
    // optionally loading a duty or toggling enable at given cycle offsets.
    task automatic measure(input int upd_off, input int upd_val, input int dis_off, input int en_off,
                           output int hi, output int len, output int busy_lo, output int rdy_bad);
        bit sent;
        sent = 1'b0;
        hi = 0; len = 0; busy_lo = 0; rdy_bad = 0;
        do begin
            @(negedge clk);
            len++;
            duty_valid = 1'b0;
            if (pwm_out) hi++;
            if (!period_end && !busy) busy_lo++;
            if (sent && !period_end && duty_ready) rdy_bad++;
            if (len == upd_off) begin
                duty_valid = 1'b1;
                duty_in = CNT_W'(upd_val);
                sent = 1'b1;
            end
            if (len == dis_off) enable = 1'b0;
            if (len == en_off)  enable = 1'b1;
        end while (!period_end && len < 200);
    endtask

    task automatic load_idle(input int val);
        @(negedge clk);
        duty_valid = 1'b1;
        duty_in = CNT_W'(val);
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        int pe_cnt, busy_cnt;
        rst = 1'b0; enable = 1'b0; duty_valid = 1'b0; duty_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pwm_out, period_end, busy, duty_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_outputs: pwm/pe/busy/ready=%b, required 0001", {pwm_out, period_end, busy, duty_ready});
        end
        rst = 1'b1;
        pe_cnt = 0; busy_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (period_end) pe_cnt++;
            if (busy || pwm_out) busy_cnt++;
        end
        n_checks++;
        if (pe_cnt !== 0 || busy_cnt !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: period_end=%0d busy_or_pwm=%0d cycles, required 0 and 0", pe_cnt, busy_cnt);
        end
    endtask

    task automatic test_basic();
        int hi, len, bl, rb;
        load_idle(3);
        n_checks++;
        if (duty_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_low: duty_ready=%0b, required 0", duty_ready);
        end
        enable = 1'b1;
        model_duty = 3;
        wait_pe();
        for (int i = 0; i < 3; i++) begin
            measure(-1, 0, -1, -1, hi, len, bl, rb);
            n_checks++;
            if (hi !== exp_hi(model_duty) || len !== WIN || bl !== 0) begin
                n_fail++;
                $display("FAIL basic_period%0d: hi=%0d len=%0d busy_lo=%0d, required %0d %0d 0", i, hi, len, bl, exp_hi(model_duty), WIN);
            end
        end
    endtask

    task automatic test_update();
        int hi, len, bl, rb;
        measure(10, 7, -1, -1, hi, len, bl, rb);
        n_checks++;
        if (hi !== exp_hi(3) || len !== WIN || rb !== 0 || duty_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL update_current: hi=%0d len=%0d ready_early=%0d ready_at_wrap=%0b, required %0d %0d 0 1", hi, len, rb, duty_ready, exp_hi(3), WIN);
        end
        model_duty = 7;
        measure(-1, 0, -1, -1, hi, len, bl, rb);
        n_checks++;
        if (hi !== exp_hi(7)) begin
            n_fail++;
            $display("FAIL update_next: hi=%0d, required %0d", hi, exp_hi(7));
        end
    endtask

    task automatic test_boundary();
        int hi, len, bl, rb;
        int vals[3] = '{0, 10, 200};
        for (int i = 0; i < 3; i++) begin
            measure(12, vals[i], -1, -1, hi, len, bl, rb);
            n_checks++;
            if (hi !== exp_hi(model_duty) || len !== WIN) begin
                n_fail++;
                $display("FAIL boundary_before_%0d: hi=%0d len=%0d, required %0d %0d", vals[i], hi, len, exp_hi(model_duty), WIN);
            end
            model_duty = vals[i];
        end
        measure(-1, 0, -1, -1, hi, len, bl, rb);
        n_checks++;
        if (hi !== exp_hi(model_duty) || len !== WIN) begin
            n_fail++;
            $display("FAIL boundary_200: hi=%0d len=%0d, required %0d %0d", hi, len, exp_hi(model_duty), WIN);
        end
    endtask

    task automatic test_drain();
        int hi, len, bl, rb, pe_cnt, act_cnt;
        measure(5, 5, -1, -1, hi, len, bl, rb);
        model_duty = 5;
        // enable drops at cnt=4 and returns at cnt=6
        measure(-1, 0, 17, 25, hi, len, bl, rb);
        n_checks++;
        if (hi !== exp_hi(5) || len !== WIN || bl !== 0) begin
            n_fail++;
            $display("FAIL drain_resume: hi=%0d len=%0d busy_lo=%0d, required %0d %0d 0", hi, len, bl, exp_hi(5), WIN);
        end
        measure(-1, 0, 17, -1, hi, len, bl, rb);
        n_checks++;
        if (hi !== exp_hi(5) || len !== WIN || bl !== 0) begin
            n_fail++;
            $display("FAIL drain_complete: hi=%0d len=%0d busy_lo=%0d, required %0d %0d 0", hi, len, bl, exp_hi(5), WIN);
        end
        pe_cnt = 0; act_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (period_end) pe_cnt++;
            if (busy || pwm_out) act_cnt++;
        end
        n_checks++;
        if (pe_cnt !== 0 || act_cnt !== 0) begin
            n_fail++;
            $display("FAIL drain_idle: period_end=%0d busy_or_pwm=%0d, required 0 0", pe_cnt, act_cnt);
        end
    endtask

    task automatic test_pend_full();
        int hi, len, bl, rb;
        load_idle(2);
        load_idle(9);
        n_checks++;
        if (duty_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_full_ready: duty_ready=%0b, required 0", duty_ready);
        end
        enable = 1'b1;
        model_duty = 2;
        wait_pe();
        for (int i = 0; i < 2; i++) begin
            measure(-1, 0, -1, -1, hi, len, bl, rb);
            n_checks++;
            if (hi !== exp_hi(2)) begin
                n_fail++;
                $display("FAIL pend_full_keep%0d: hi=%0d, required %0d", i, hi, exp_hi(2));
            end
        end
    endtask

    task automatic test_random();
        int hi, len, bl, rb, d, off;
        for (int i = 0; i < 8; i++) begin
            d   = int'($urandom_range(0, 15));
            off = int'($urandom_range(2, 38));
            measure(off, d, -1, -1, hi, len, bl, rb);
            n_checks++;
            if (hi !== exp_hi(model_duty) || len !== WIN) begin
                n_fail++;
                $display("FAIL random%0d: duty=%0d hi=%0d len=%0d, required %0d %0d", i, model_duty, hi, len, exp_hi(model_duty), WIN);
            end
            model_duty = d;
        end
        measure(-1, 0, -1, -1, hi, len, bl, rb);
        n_checks++;
        if (hi !== exp_hi(model_duty)) begin
            n_fail++;
            $display("FAIL random_last: duty=%0d hi=%0d, required %0d", model_duty, hi, exp_hi(model_duty));
        end
    endtask

    task automatic test_rst_mid();
        int hi, len, bl, rb, k;
        measure(4, 9, -1, -1, hi, len, bl, rb);
        measure(-1, 0, -1, -1, hi, len, bl, rb);
        repeat (6) @(negedge clk);
        duty_valid = 1'b1;
        duty_in = CNT_W'(7);
        @(negedge clk);
        duty_valid = 1'b0;
        n_checks++;
        if (pwm_out !== 1'b1 || duty_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_pre: pwm=%0b ready=%0b, required 1 0", pwm_out, duty_ready);
        end
        div_run = 1'b0;
        div_hold = 1'b1;
        #3;
        rst = 1'b0;
        enable = 1'b0;
        #1;
        n_checks++;
        if ({pwm_out, period_end, busy, duty_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_async: pwm/pe/busy/ready=%b, required 0001", {pwm_out, period_end, busy, duty_ready});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || duty_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_idle: busy=%0b ready=%0b, required 0 1", busy, duty_ready);
        end
        load_idle(1);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || pwm_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_no_tick_while_high: busy=%0b pwm=%0b, required 1 1", busy, pwm_out);
        end
        div_run = 1'b1;
        k = 0;
        while (k < 20 && pwm_out) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fresh_rise_tick: pwm=%0b after %0d cycles, required 0", pwm_out, k);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_update();
        test_boundary();
        test_drain();
        test_pend_full();
        test_random();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
